// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-port DataMemory.
// Each access is latch (IDLE), access (ACCESS), then acknowledge (DONE).
// Memory strobes, address and write data all come straight from flops.
module dmem_arbiter #(
  parameter int AW        = 24,
  parameter int DW        = 24,
  parameter int FIXED_PRI = 0
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          Req0,
  input  logic          Wr0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] WData0,
  output logic          Ack0,
  output logic [DW-1:0] RData0,
  input  logic          Req1,
  input  logic          Wr1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData1,
  output logic          Ack1,
  output logic [DW-1:0] RData1,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] MemRData,
  output logic          Busy,
  output logic          GrantId
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic          wr_lat;
  logic          last_gnt;
  logic          any_req;
  logic          win;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Winner selection; a tie goes to port 0 under fixed priority,
  // otherwise to the port that was not granted last.
  always_comb begin
    any_req = Req0 | Req1;
    win     = 1'b0;
    if (Req0 && Req1) begin
      win = (FIXED_PRI != 0) ? 1'b0 : ~last_gnt;
    end else if (Req1) begin
      win = 1'b1;
    end
    sel_wr    = win ? Wr1    : Wr0;
    sel_addr  = win ? Addr1  : Addr0;
    sel_wdata = win ? WData1 : WData0;
  end

  // State register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered memory interface, grant, acks and read-data capture.
  // Strobes are set on the IDLE->ACCESS edge so they last exactly ACCESS.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      MemAddr  <= '0;
      MemWData <= '0;
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      RData0   <= '0;
      RData1   <= '0;
      GrantId  <= 1'b0;
      wr_lat   <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            GrantId  <= win;
            last_gnt <= win;
            wr_lat   <= sel_wr;
            MemAddr  <= sel_addr;
            MemWData <= sel_wdata;
            MemWrite <= sel_wr;
            MemRead  <= ~sel_wr;
          end
        end
        ACCESS: begin
          if (!wr_lat) begin
            if (GrantId) RData1 <= MemRData;
            else         RData0 <= MemRData;
          end
          Ack0 <= ~GrantId;
          Ack1 <= GrantId;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port 24-bit DataMemory (synchronous write, combinational read). It shares the memory between the CPU data port (port 0) and a loader/DMA port (port 1). Each access runs through a fixed three-phase sequence: latch, access and acknowledge. Memory strobes and address/data are driven from registers, so the memory sees a glitch-free, single-cycle MemRead or MemWrite.

Parameters:
AW, 24, address width.
DW, 24, data width.
FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins simultaneous requests.

Ports:
Clock  input  1  system clock, rising edge.
ResetN  input  1  asynchronous active-low reset.
Req0  input  1  port 0 request; held until Ack0.
Wr0  input  1  port 0: 1 = write, 0 = read.
Addr0  input  AW  port 0 address.
WData0  input  DW  port 0 write data.
Ack0  output  1  one-cycle completion pulse to port 0.
RData0  output  DW  registered read data for port 0; valid while Ack0 is high, held afterwards.
Req1, Wr1, Addr1, WData1, Ack1, RData1  as port 0, for port 1.
MemAddr  output  AW  to DataMemory Adresa.
MemWData  output  DW  to DataMemory WriteData.
MemWrite  output  1  to DataMemory MemWrite.
MemRead  output  1  to DataMemory MemRead.
MemRData  input  DW  from DataMemory ReadData.
Busy  output  1  high in any state other than IDLE.
GrantId  output  1  port currently owning the memory; valid when Busy is high.

Behaviour:
- Clock and reset: one clock domain (Clock). ResetN is asynchronous and active-low.
- Reset (ResetN low, asynchronous):
  - State goes to IDLE.
  - MemWrite = MemRead = 0; MemAddr = MemWData = 0.
  - Ack0 = Ack1 = 0; RData0 = RData1 = 0; Busy = 0; GrantId = 0.
  - Round-robin pointer set to favour port 0.
  - A reset during ACCESS aborts the access. No Ack is issued. A write in progress may or may not have committed.
- State machine (states IDLE, ACCESS, DONE):
  - IDLE: Req0 and Req1 are sampled only in this state.
    - If neither is high, stay in IDLE.
    - Otherwise pick a winner. Latch its Wr/Addr/WData into MemAddr/MemWData and its write flag. Set GrantId to the winner. Go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - MemWrite = latched Wr; MemRead = !latched Wr.
    - MemAddr and MemWData are stable for the whole cycle.
    - At the closing edge, DataMemory commits a write. For a read, MemRData is captured into RData of the winning port.
    - Go to DONE.
  - DONE (exactly 1 cycle):
    - MemWrite = MemRead = 0.
    - Ack of the winning port is high. For a read, its RData is valid.
    - Go to IDLE.
- Latency: a request sampled at edge k gives ACCESS in cycle k+1 and Ack in cycle k+2. The next request can be sampled at the end of cycle k+3. Peak throughput is one access per 3 cycles.
- Handshake:
  - The requester holds Req/Wr/Addr/WData stable until Ack.
  - The requester must drop Req during the Ack cycle. A Req still high in the following IDLE cycle is treated as a new request.
  - Changes to a request after it has been latched have no effect on the access in flight.
- Arbitration:
  - FIXED_PRI = 1: port 0 wins ties.
  - FIXED_PRI = 0: on a tie, the port not granted last wins.
  - The pointer updates on every grant, including uncontested ones.
  - A lone requester is always granted. No starvation: with both ports requesting continuously, grants alternate 0, 1, 0, 1, ...
- Strobes: MemWrite and MemRead are never high together. Both are 0 outside ACCESS.
- Read data: RData of the non-winning port is unchanged. Write accesses leave RData unchanged.
- Width: addresses and data pass through unmodified. There is no address translation and no bounds checking.

Test Plan:
- Single write: port 0, Req0 = 1, Wr0 = 1, Addr0 = 2, WData0 = 30 → ACCESS cycle with MemWrite = 1, MemAddr = 2, MemWData = 30; Ack0 pulses 2 cycles after the request is sampled; MemRead stays 0.
- Read-back: port 1 reads Addr1 = 2 after the single write → MemRead = 1 for exactly 1 cycle; Ack1 with RData1 = 30; RData0 unchanged.
- Simultaneous requests, FIXED_PRI = 0, both ports holding Req: port 0 writes 0x000011 to addr 5, port 1 writes 0x000022 to addr 6 → port 0 is served first, then port 1 next round; GrantId sequence 0, 1; continuous requests alternate with no starvation.
- FIXED_PRI = 1, both ports requesting reads continuously for 4 rounds → port 0 wins every tie; port 1 is granted only in rounds where Req0 is low.
- Reset mid-ACCESS: assert ResetN = 0 while MemWrite = 1 → MemWrite, Ack, Busy and RData all 0 immediately (asynchronous); state is IDLE after release; no Ack for the aborted request.
- Handshake hold violation: Req0 held high one cycle past Ack0 → a second identical access is issued, and Ack0 pulses again 3 cycles later.
